// File: rtl/uart_receiver.sv
// UART receive stage: 8N1 frames at CLKS_PER_BIT clocks per bit, held-valid/ack byte output.
// Define UART_RX_PARITY_EN for 8E1 frames with an extra even-parity bit and parity_err reporting.
module uart_receiver #(
   parameter int CLKS_PER_BIT = 1086
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       busy,
   output logic       frame_err,
   output logic       overrun_err,
   output logic       parity_err
);

   localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       idx, idx_nxt;
   logic [7:0]       shreg, shreg_nxt;
   logic             rxd_p0, rxd_s;
   logic             stop_ok;
   logic             frame_nxt;
`ifdef UART_RX_PARITY_EN
   logic             par_bit, par_bit_nxt;
   logic             par_err_nxt;
`endif

   assign busy = (state != IDLE);

   // Input synchroniser: rxd is asynchronous to clk
   always_ff @(posedge clk) begin
      if (reset) begin
         rxd_p0 <= 1'b1;
         rxd_s  <= 1'b1;
      end else begin
         rxd_p0 <= rxd;
         rxd_s  <= rxd_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
      end
   end

   // Data-path registers carry no reset; every bit is rewritten before it is used
   always_ff @(posedge clk) begin
      shreg <= shreg_nxt;
`ifdef UART_RX_PARITY_EN
      par_bit <= par_bit_nxt;
`endif
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      shreg_nxt = shreg;
      stop_ok   = 1'b0;
      frame_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_nxt = par_bit;
      par_err_nxt = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (!rxd_s) begin
               state_nxt = START;
               cnt_nxt   = '0;
            end
         end
         START: begin
            if (cnt == HALF_M1) begin
               cnt_nxt = '0;
               if (!rxd_s) begin
                  state_nxt = DATA;
                  idx_nxt   = '0;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         DATA: begin
            if (cnt == FULL_M1) begin
               cnt_nxt        = '0;
               shreg_nxt[idx] = rxd_s;
               if (idx == 3'd7) begin
                  idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end else begin
                  idx_nxt = idx + 3'd1;
               end
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt == FULL_M1) begin
               cnt_nxt     = '0;
               par_bit_nxt = rxd_s;
               state_nxt   = STOP;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
`endif
         STOP: begin
            if (cnt == FULL_M1) begin
               cnt_nxt = '0;
               if (!rxd_s) begin
                  frame_nxt = 1'b1;
                  state_nxt = WAIT_HIGH;
               end else begin
                  state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                  if (par_bit != ^shreg) par_err_nxt = 1'b1;
                  else                   stop_ok     = 1'b1;
`else
                  stop_ok = 1'b1;
`endif
               end
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         WAIT_HIGH: begin
            if (rxd_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Delivery: an ack in the same cycle as a new byte frees the slot, so no overrun
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         overrun_err <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         overrun_err <= 1'b0;
         frame_err   <= frame_nxt;
         if (stop_ok) begin
            if (!rx_valid || rx_ack) begin
               rx_data  <= shreg;
               rx_valid <= 1'b1;
            end else begin
               overrun_err <= 1'b1;
            end
         end else if (rx_ack) begin
            rx_valid <= 1'b0;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (reset) parity_err <= 1'b0;
      else       parity_err <= par_err_nxt;
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule
